mem_align_lsu: RTL and testbench

Parametrised load/store alignment unit between the execute stage and the data memory port. It accepts one sub-word or word access per transaction and drives a word-aligned memory request with byte enables. It waits for the memory acknowledge with a bounded timeout, then returns sign- or zero-extended load data, or an error response. Supported endianness is big-endian (the default) or little-endian; byte, halfword, word and, when 64-bit, doubleword accesses are supported.

---
 rtl/mem_align_lsu_pkg.sv | 47 ++++
 rtl/mem_align_lsu_align.sv | 75 +++++++
 rtl/mem_align_lsu.sv | 208 ++++++++++++++++++++
 tb/tb_mem_align_lsu.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_align_lsu_pkg.sv
// Shared encodings, FSM state type and access-legality helpers for the
// load/store alignment unit.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } lsu_state_e;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        logic [3:0] n;
        case (size)
            SZ_B:    n = 4'd1;
            SZ_H:    n = 4'd2;
            SZ_W:    n = 4'd4;
            SZ_D:    n = 4'd8;
            default: n = 4'd1;
        endcase
        return n;
    endfunction

    // A doubleword is only legal on a 64-bit port.
    function automatic logic access_bad(input logic [1:0] size,
                                        input logic [2:0] off,
                                        input logic       wide);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = off[0];
            SZ_W:    bad = |off[1:0];
            SZ_D:    bad = !wide || (|off);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_align_lsu_align.sv
// Combinational lane steering: byte enables, store replication and
// load-field extraction with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int BIG_ENDIAN = 1
) (
    input  logic [$clog2(DATA_W/8)-1:0] offset,
    input  logic [1:0]                  size,
    input  logic                        uns,
    input  logic [DATA_W-1:0]           wdata,
    input  logic [DATA_W-1:0]           rdata,
    output logic [DATA_W/8-1:0]         be,
    output logic [DATA_W-1:0]           wdata_rep,
    output logic [DATA_W-1:0]           rdata_ext
);

    localparam int         NB   = DATA_W / 8;
    localparam logic [3:0] NB_L = 4'(NB);

    logic [3:0]        nbytes_s;
    logic [3:0]        lo_lane_s;
    logic [DATA_W-1:0] shifted_s;
    logic [DATA_W-1:0] field_mask_s;
    logic              sign_s;

    // Lowest lane covered by the access; big-endian mirrors the offset.
    always_comb begin
        nbytes_s = (size_bytes(size) > NB_L) ? NB_L : size_bytes(size);
        if (BIG_ENDIAN != 0) begin
            lo_lane_s = NB_L - 4'(offset) - nbytes_s;
        end else begin
            lo_lane_s = 4'(offset);
        end
    end

    // Byte enables over the addressed lanes only.
    always_comb begin
        be = '0;
        for (int i = 0; i < NB; i++) begin
            be[i] = (4'(i) >= lo_lane_s) && (4'(i) < (lo_lane_s + nbytes_s));
        end
    end

    // Right-justified store value repeated across every lane group.
    always_comb begin
        wdata_rep = '0;
        for (int i = 0; i < NB; i++) begin
            wdata_rep[8*i +: 8] = 8'(wdata >> {(3'(i) & (nbytes_s[2:0] - 3'd1)), 3'b000});
        end
    end

    // Bring the field down to bit 0, then extend from the field's own MSB.
    always_comb begin
        shifted_s    = rdata >> {lo_lane_s[2:0], 3'b000};
        field_mask_s = '0;
        for (int i = 0; i < DATA_W; i++) begin
            field_mask_s[i] = (7'(i) < {nbytes_s, 3'b000});
        end
        case (size)
            SZ_B:    sign_s = shifted_s[7];
            SZ_H:    sign_s = shifted_s[15];
            SZ_W:    sign_s = shifted_s[31];
            SZ_D:    sign_s = shifted_s[DATA_W-1];
            default: sign_s = shifted_s[7];
        endcase
        if (sign_s && !uns) begin
            rdata_ext = shifted_s | ~field_mask_s;
        end else begin
            rdata_ext = shifted_s & field_mask_s;
        end
    end

endmodule

// File: rtl/mem_align_lsu.sv
// Load/store alignment unit: accepts one access, issues a word-aligned
// memory request with byte enables, and returns an extended result or error.
module mem_align_lsu
    import lsu_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int BIG_ENDIAN  = 1,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic [1:0]          resp_err,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int OFF_W = $clog2(DATA_W / 8);
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic WIDE = (DATA_W == 64) ? 1'b1 : 1'b0;

    lsu_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W/8-1:0] mem_be_q, mem_be_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic [OFF_W-1:0]    off_q, off_d;
    logic                resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
    logic [1:0]          resp_err_q, resp_err_d;

    logic [OFF_W-1:0]    al_off_s;
    logic [1:0]          al_size_s;
    logic                al_uns_s;
    logic [DATA_W/8-1:0] al_be_s;
    logic [DATA_W-1:0]   al_wdata_s;
    logic [DATA_W-1:0]   al_rdata_s;
    logic                req_bad_s;
    logic                timeout_hit_s;

    // The aligner sees the live request while idle and the held access otherwise.
    always_comb begin
        if (state_q == ST_IDLE) begin
            al_off_s  = req_addr[OFF_W-1:0];
            al_size_s = req_size;
            al_uns_s  = req_unsigned;
        end else begin
            al_off_s  = off_q;
            al_size_s = size_q;
            al_uns_s  = uns_q;
        end
    end

    lsu_align #(
        .DATA_W     (DATA_W),
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_align (
        .offset    (al_off_s),
        .size      (al_size_s),
        .uns       (al_uns_s),
        .wdata     (req_wdata),
        .rdata     (mem_rdata),
        .be        (al_be_s),
        .wdata_rep (al_wdata_s),
        .rdata_ext (al_rdata_s)
    );

    // Request legality and timeout detection.
    always_comb begin
        req_bad_s = access_bad(req_size, 3'(req_addr[OFF_W-1:0]), WIDE);
        if (TIMEOUT_CYC != 0) begin
            timeout_hit_s = (cnt_q == CNT_LAST);
        end else begin
            timeout_hit_s = 1'b0;
        end
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        size_d       = size_q;
        uns_d        = uns_q;
        off_d        = off_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = {DATA_W{1'b0}};
        resp_err_d   = ERR_OK;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_bad_s) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = ERR_MISALIGN;
                end else if (req_valid) begin
                    state_d     = ST_WAIT;
                    cnt_d       = {CNT_W{1'b0}};
                    mem_req_d   = 1'b1;
                    mem_we_d    = req_we;
                    mem_addr_d  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    mem_be_d    = al_be_s;
                    mem_wdata_d = al_wdata_s;
                    size_d      = req_size;
                    uns_d       = req_unsigned;
                    off_d       = req_addr[OFF_W-1:0];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // An ack in the final allowed cycle still completes normally.
                if (mem_ack) begin
                    state_d      = ST_RESP;
                    mem_req_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = ERR_OK;
                    if (mem_we_q) begin
                        resp_rdata_d = {DATA_W{1'b0}};
                    end else begin
                        resp_rdata_d = al_rdata_s;
                    end
                end else if (timeout_hit_s) begin
                    state_d      = ST_RESP;
                    mem_req_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = ERR_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= {ADDR_W{1'b0}};
            mem_be_q     <= {(DATA_W/8){1'b0}};
            mem_wdata_q  <= {DATA_W{1'b0}};
            size_q       <= SZ_B;
            uns_q        <= 1'b0;
            off_q        <= {OFF_W{1'b0}};
            resp_valid_q <= 1'b0;
            resp_rdata_q <= {DATA_W{1'b0}};
            resp_err_q   <= ERR_OK;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            off_q        <= off_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_be     = mem_be_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_align_lsu.sv
// Drives three configurations (32-bit big-endian, 32-bit little-endian,
// 64-bit big-endian) in lockstep and checks each against a byte-level model.
module tb_mem_align_lsu;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid, req_we, req_unsigned, mem_ack;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [63:0] req_wdata, mem_rdata;

    logic        rdy0, rv0, mq0, mw0, rdy1, rv1, mq1, mw1, rdy2, rv2, mq2, mw2;
    logic [1:0]  er0, er1, er2;
    logic [31:0] rd0, wd0, ma0, rd1, wd1, ma1, ma2;
    logic [63:0] rd2, wd2;
    logic [3:0]  be0, be1;
    logic [7:0]  be2;

    logic        o_rdy[3], o_rv[3], o_req[3], o_we[3];
    logic [1:0]  o_err[3];
    logic [63:0] o_rd[3], o_wd[3];
    logic [7:0]  o_be[3];
    logic [31:0] o_ma[3];

    logic [63:0] cap_rd[3], cap_wd[3];
    logic [1:0]  cap_err[3];
    logic [7:0]  cap_be[3];
    logic [31:0] cap_ma[3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_align_lsu #(.DATA_W(32), .ADDR_W(32), .BIG_ENDIAN(1), .TIMEOUT_CYC(T)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy0), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata[31:0]), .resp_valid(rv0), .resp_rdata(rd0), .resp_err(er0),
        .mem_req(mq0), .mem_we(mw0), .mem_addr(ma0), .mem_be(be0), .mem_wdata(wd0),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata[31:0]));

    mem_align_lsu #(.DATA_W(32), .ADDR_W(32), .BIG_ENDIAN(0), .TIMEOUT_CYC(T)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata[31:0]), .resp_valid(rv1), .resp_rdata(rd1), .resp_err(er1),
        .mem_req(mq1), .mem_we(mw1), .mem_addr(ma1), .mem_be(be1), .mem_wdata(wd1),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata[31:0]));

    mem_align_lsu #(.DATA_W(64), .ADDR_W(32), .BIG_ENDIAN(1), .TIMEOUT_CYC(T)) dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy2), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(rv2), .resp_rdata(rd2), .resp_err(er2),
        .mem_req(mq2), .mem_we(mw2), .mem_addr(ma2), .mem_be(be2), .mem_wdata(wd2),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata));

    assign o_rdy[0] = rdy0; assign o_rdy[1] = rdy1; assign o_rdy[2] = rdy2;
    assign o_rv[0]  = rv0;  assign o_rv[1]  = rv1;  assign o_rv[2]  = rv2;
    assign o_req[0] = mq0;  assign o_req[1] = mq1;  assign o_req[2] = mq2;
    assign o_we[0]  = mw0;  assign o_we[1]  = mw1;  assign o_we[2]  = mw2;
    assign o_err[0] = er0;  assign o_err[1] = er1;  assign o_err[2] = er2;
    assign o_rd[0]  = {32'h0, rd0}; assign o_rd[1] = {32'h0, rd1}; assign o_rd[2] = rd2;
    assign o_wd[0]  = {32'h0, wd0}; assign o_wd[1] = {32'h0, wd1}; assign o_wd[2] = wd2;
    assign o_be[0]  = {4'h0, be0};  assign o_be[1] = {4'h0, be1};  assign o_be[2] = be2;
    assign o_ma[0]  = ma0;  assign o_ma[1]  = ma1;  assign o_ma[2]  = ma2;

    function automatic int dw_of(input int d);
        return (d == 2) ? 64 : 32;
    endfunction

    function automatic int bem_of(input int d);
        return (d == 1) ? 0 : 1;
    endfunction

    task automatic chk(input string name, input int d, input int c,
                       input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d idx%0d: got %h expected %h", name, d, c, act, exp);
        end
    endtask

    // Memory word viewed as an array of byte addresses; the access reads or
    // writes consecutive addresses starting at the offset.
    function automatic void model(input int dw, input int bem, input logic we,
                                  input logic [1:0] size, input logic uns,
                                  input logic [31:0] addr, input logic [63:0] wdata,
                                  input logic [63:0] rdata, output logic bad,
                                  output logic [63:0] rd, output logic [7:0] be,
                                  output logic [63:0] wd, output logic [31:0] ma);
        int nb, n, off;
        logic [7:0]  mem_b[8];
        logic [63:0] val, fmask, dmask;
        nb    = dw / 8;
        n     = 1 << size;
        off   = int'(addr % 32'(nb));
        bad   = (n > nb) || ((off % n) != 0);
        ma    = addr - 32'(off);
        dmask = (dw == 64) ? {64{1'b1}} : 64'h0000_0000_FFFF_FFFF;
        fmask = (n == 8) ? {64{1'b1}} : ((64'd1 << (8 * n)) - 64'd1);
        for (int j = 0; j < 8; j++) mem_b[j] = 8'h00;
        for (int j = 0; j < nb; j++) mem_b[j] = rdata[8 * ((bem != 0) ? (nb - 1 - j) : j) +: 8];
        val = 64'h0;
        be  = 8'h00;
        if (!bad) begin
            for (int i = 0; i < n; i++) begin
                int a;
                a = off + i;
                be[(bem != 0) ? (nb - 1 - a) : a] = 1'b1;
                if (bem != 0) val = (val << 8) | 64'(mem_b[a]);
                else          val = val | (64'(mem_b[a]) << (8 * i));
            end
        end
        if (!uns && val[8 * n - 1]) val = val | ~fmask;
        rd = we ? 64'h0 : (val & dmask);
        wd = 64'h0;
        if (!bad) begin
            for (int k = 0; k * n < nb; k++) wd = wd | ((wdata & fmask) << (8 * n * k));
        end
        wd = wd & dmask;
    endfunction

    // One transaction: accept in cycle 0, optional ack in cycle ack_cyc,
    // then per-cycle checks of every DUT for T+3 cycles.
    task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [63:0] wdata,
                           input logic [63:0] rdata, input int ack_cyc);
        logic        e_bad[3];
        logic [63:0] e_rd[3], e_wd[3];
        logic [7:0]  e_be[3];
        logic [31:0] e_ma[3];
        logic [1:0]  x_err[3];
        int          rc[3];
        int          wend;
        logic        ok_ack;
        ok_ack = (ack_cyc >= 1) && (ack_cyc <= T);
        wend   = ok_ack ? ack_cyc : T;
        for (int d = 0; d < 3; d++) begin
            model(dw_of(d), bem_of(d), we, size, uns, addr, wdata, rdata,
                  e_bad[d], e_rd[d], e_be[d], e_wd[d], e_ma[d]);
            rc[d]    = e_bad[d] ? 1 : wend + 1;
            x_err[d] = e_bad[d] ? 2'b01 : (ok_ack ? 2'b00 : 2'b10);
            if (x_err[d] != 2'b00) e_rd[d] = 64'h0;
            cap_rd[d] = 'x; cap_wd[d] = 'x; cap_err[d] = 'x; cap_be[d] = 'x; cap_ma[d] = 'x;
        end
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; mem_rdata = rdata; mem_ack = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 1; c <= T + 3; c++) begin
            mem_ack = (c == ack_cyc);
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                chk("mem_req", d, c, 64'(o_req[d]), 64'(!e_bad[d] && (c <= wend)));
                chk("resp_valid", d, c, 64'(o_rv[d]), 64'(c == rc[d]));
                chk("req_ready", d, c, 64'(o_rdy[d]), 64'(c > rc[d]));
                if (!e_bad[d] && (c <= wend)) begin
                    chk("mem_addr", d, c, 64'(o_ma[d]), 64'(e_ma[d]));
                    chk("mem_be", d, c, 64'(o_be[d]), 64'(e_be[d]));
                    chk("mem_wdata", d, c, o_wd[d], e_wd[d]);
                    chk("mem_we", d, c, 64'(o_we[d]), 64'(we));
                    if (c == 1) begin
                        cap_ma[d] = o_ma[d]; cap_be[d] = o_be[d]; cap_wd[d] = o_wd[d];
                    end
                end
                if (c == rc[d]) begin
                    chk("resp_rdata", d, c, o_rd[d], e_rd[d]);
                    chk("resp_err", d, c, 64'(o_err[d]), 64'(x_err[d]));
                    cap_rd[d] = o_rd[d]; cap_err[d] = o_err[d];
                end
            end
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          ack;
        logic        acc;
        logic [1:0]  err;
        logic [31:0] e_rd;
        logic [31:0] e_le;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        logic [31:0] e_ma;
    } vec_t;

    vec_t vecs[12];

    initial begin
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 64'h0; mem_rdata = 64'h0; mem_ack = 1'b0;

        #2;
        for (int d = 0; d < 3; d++) begin
            chk("rst_ready", d, 0, 64'(o_rdy[d]), 64'd1);
            chk("rst_mem_req", d, 0, 64'(o_req[d]), 64'd0);
            chk("rst_mem_we", d, 0, 64'(o_we[d]), 64'd0);
            chk("rst_mem_be", d, 0, 64'(o_be[d]), 64'd0);
            chk("rst_mem_addr", d, 0, 64'(o_ma[d]), 64'd0);
            chk("rst_mem_wdata", d, 0, o_wd[d], 64'd0);
            chk("rst_resp_valid", d, 0, 64'(o_rv[d]), 64'd0);
            chk("rst_resp_rdata", d, 0, o_rd[d], 64'd0);
            chk("rst_resp_err", d, 0, 64'(o_err[d]), 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        //         we    size   uns   addr          wdata      rdata            ack acc  err    e_rd          e_le          be     wd            ma
        vecs[0]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0101, 64'h0, 64'h12F4_5678, 1, 1'b1, 2'b00, 32'hFFFF_FFF4, 32'h0000_0056, 4'b0100, 32'h0, 32'h0000_0100};
        vecs[1]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0101, 64'h0, 64'h12F4_5678, 2, 1'b1, 2'b00, 32'h0000_00F4, 32'h0000_0056, 4'b0100, 32'h0, 32'h0000_0100};
        vecs[2]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0102, 64'h0, 64'h1234_8001, 3, 1'b1, 2'b00, 32'hFFFF_8001, 32'h0000_1234, 4'b0011, 32'h0, 32'h0000_0100};
        vecs[3]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0104, 64'h0, 64'h89AB_CDEF, 1, 1'b1, 2'b00, 32'h89AB_CDEF, 32'h89AB_CDEF, 4'b1111, 32'h0, 32'h0000_0104};
        vecs[4]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0003, 64'hAB, 64'h5555_5555, 2, 1'b1, 2'b00, 32'h0, 32'h0, 4'b0001, 32'hABAB_ABAB, 32'h0};
        vecs[5]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0002, 64'h1234, 64'h5555_5555, 1, 1'b1, 2'b00, 32'h0, 32'h0, 4'b0011, 32'h1234_1234, 32'h0};
        vecs[6]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0001, 64'h0, 64'h1234_5678, 1, 1'b0, 2'b01, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0};
        vecs[7]  = '{1'b0, 2'b11, 1'b0, 32'h0000_0008, 64'h0, 64'h1234_5678, 2, 1'b0, 2'b01, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0};
        vecs[8]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0200, 64'h0, 64'h1234_5678, 0, 1'b1, 2'b10, 32'h0, 32'h0, 4'b1111, 32'h0, 32'h0000_0200};
        vecs[9]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0204, 64'h0, 64'hCAFE_F00D, 4, 1'b1, 2'b00, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'b1111, 32'h0, 32'h0000_0204};
        vecs[10] = '{1'b0, 2'b01, 1'b1, 32'h0000_0106, 64'h0, 64'hFFFF_8001, 2, 1'b1, 2'b00, 32'h0000_8001, 32'h0000_FFFF, 4'b0011, 32'h0, 32'h0000_0104};
        vecs[11] = '{1'b0, 2'b00, 1'b0, 32'h0000_0100, 64'h0, 64'h7F00_0000, 1, 1'b1, 2'b00, 32'h0000_007F, 32'h0, 4'b1000, 32'h0, 32'h0000_0100};

        for (int i = 0; i < 12; i++) begin
            run_txn(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr,
                    vecs[i].wdata, vecs[i].rdata, vecs[i].ack);
            chk("tab_rdata", 0, i, cap_rd[0], {32'h0, vecs[i].e_rd});
            chk("tab_err", 0, i, 64'(cap_err[0]), 64'(vecs[i].err));
            chk("tab_le_rdata", 1, i, cap_rd[1], {32'h0, vecs[i].e_le});
            if (vecs[i].acc) begin
                chk("tab_be", 0, i, 64'(cap_be[0]), 64'(vecs[i].e_be));
                chk("tab_wdata", 0, i, cap_wd[0], {32'h0, vecs[i].e_wd});
                chk("tab_addr", 0, i, 64'(cap_ma[0]), 64'(vecs[i].e_ma));
            end
        end

        // Reset while waiting: request drops at once and a late ack is ignored.
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h0000_0040; mem_rdata = 64'h1111_2222_3333_4444;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) chk("rstwait_req_before", d, 0, 64'(o_req[d]), 64'd1);
        #1 rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rstwait_req_drop", d, 0, 64'(o_req[d]), 64'd0);
            chk("rstwait_ready", d, 0, 64'(o_rdy[d]), 64'd1);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                chk("rstwait_no_resp", d, k, 64'(o_rv[d]), 64'd0);
                chk("rstwait_no_req", d, k, 64'(o_req[d]), 64'd0);
                chk("rstwait_idle", d, k, 64'(o_rdy[d]), 64'd1);
            end
        end
        @(posedge clk); #1;

        for (int i = 0; i < 80; i++) begin
            logic        r_we, r_uns;
            logic [1:0]  r_size;
            logic [31:0] r_addr;
            logic [63:0] r_wd, r_rd;
            int          r_ack;
            r_we   = 1'($urandom_range(0, 1));
            r_uns  = 1'($urandom_range(0, 1));
            r_size = 2'($urandom_range(0, 3));
            r_addr = $urandom;
            if ($urandom_range(0, 3) != 0) r_addr = r_addr & (32'hFFFF_FFFF << r_size);
            r_wd   = {$urandom, $urandom};
            r_rd   = {$urandom, $urandom};
            r_ack  = $urandom_range(0, T + 2);
            run_txn(r_we, r_size, r_uns, r_addr, r_wd, r_rd, r_ack);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
